// File: rtl/lagarto_l15_req_arbiter.sv
// Round-robin arbiter sharing the tile's single L1.5 request port between the
// instruction-fetch (IC) and data-cache (DC) requesters. The granted request is
// registered and held on the port until the L1.5 header ack; per-requester
// outstanding counters gate eligibility, and returns are steered by source tag.
module lagarto_l15_req_arbiter #(
  parameter int unsigned REQ_W     = 128,
  parameter int unsigned MAX_OUTST = 4,
  parameter int unsigned CNT_W     = 3
) (
  input  logic             clk_i,
  input  logic             reset_l,
  input  logic             ic_req_val_i,
  input  logic [REQ_W-1:0] ic_req_data_i,
  output logic             ic_req_ack_o,
  input  logic             dc_req_val_i,
  input  logic [REQ_W-1:0] dc_req_data_i,
  output logic             dc_req_ack_o,
  output logic             l15_req_val_o,
  output logic [REQ_W-1:0] l15_req_data_o,
  output logic             l15_req_src_o,
  input  logic             l15_req_ack_i,
  input  logic             l15_rtrn_val_i,
  input  logic             l15_rtrn_src_i,
  output logic             ic_rtrn_val_o,
  output logic             dc_rtrn_val_o,
  output logic [CNT_W-1:0] ic_outst_o,
  output logic [CNT_W-1:0] dc_outst_o,
  output logic             idle_o,
  output logic             err_o
);

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_REQ  = 1'b1
  } state_e;

  // Source tag encoding shared by the request and return paths.
  localparam logic SRC_IC = 1'b0;
  localparam logic SRC_DC = 1'b1;

  localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_OUTST);

  state_e           state_q, state_d;
  logic             last_grant_q;
  logic [CNT_W-1:0] ic_cnt_q, dc_cnt_q;
  logic             err_q;

  logic ic_elig, dc_elig;
  logic grant_val, grant_src;
  logic ic_inc, dc_inc, ic_dec, dc_dec;

  // Counter update: simultaneous inc/dec cancels; a decrement at zero saturates
  // (the error flag records the underflow separately).
  function automatic logic [CNT_W-1:0] next_cnt(input logic [CNT_W-1:0] cnt,
                                                input logic inc, input logic dec);
    logic [CNT_W-1:0] res;
    res = cnt;
    if (inc && !dec)                       res = cnt + CNT_W'(1);
    else if (dec && !inc && (cnt != '0))   res = cnt - CNT_W'(1);
    return res;
  endfunction

  // Eligibility and round-robin pick; last_grant breaks ties toward the other side.
  always_comb begin
    // NOTE: every signal assigned in a combinational block gets a default first,
    // otherwise an unassigned path infers a latch.
    grant_val = 1'b0;
    grant_src = SRC_IC;
    ic_elig   = ic_req_val_i && (ic_cnt_q < MAX_CNT);
    dc_elig   = dc_req_val_i && (dc_cnt_q < MAX_CNT);
    if (ic_elig && dc_elig) begin
      grant_val = 1'b1;
      grant_src = ~last_grant_q;
    end else if (ic_elig || dc_elig) begin
      grant_val = 1'b1;
      grant_src = dc_elig ? SRC_DC : SRC_IC;
    end
  end

  // State register.
  always_ff @(posedge clk_i or negedge reset_l) begin
    if (!reset_l) state_q <= ST_IDLE;
    // NOTE: sequential state uses non-blocking assignments so every flop samples
    // pre-edge values regardless of block evaluation order.
    else          state_q <= state_d;
  end

  // Next-state logic: grant moves to REQ, header ack returns to IDLE.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (grant_val)     state_d = ST_REQ;
      ST_REQ:  if (l15_req_ack_i) state_d = ST_IDLE;
      default:                    state_d = ST_IDLE;
    endcase
  end

  // Output decode: acks, return steering, counter strobes and idle flag.
  always_comb begin
    ic_req_ack_o  = 1'b0;
    dc_req_ack_o  = 1'b0;
    if (state_q == ST_REQ && l15_req_ack_i) begin
      ic_req_ack_o = (l15_req_src_o == SRC_IC);
      dc_req_ack_o = (l15_req_src_o == SRC_DC);
    end
    ic_inc        = ic_req_ack_o;
    dc_inc        = dc_req_ack_o;
    ic_rtrn_val_o = l15_rtrn_val_i && (l15_rtrn_src_i == SRC_IC);
    dc_rtrn_val_o = l15_rtrn_val_i && (l15_rtrn_src_i == SRC_DC);
    ic_dec        = ic_rtrn_val_o;
    dc_dec        = dc_rtrn_val_o;
    l15_req_val_o = (state_q == ST_REQ);
    idle_o        = (state_q == ST_IDLE) && (ic_cnt_q == '0) && (dc_cnt_q == '0);
  end

  // Request register: payload and tag captured at grant, held through REQ.
  always_ff @(posedge clk_i or negedge reset_l) begin
    if (!reset_l) begin
      l15_req_data_o <= '0;
      l15_req_src_o  <= SRC_IC;
      last_grant_q   <= SRC_DC;
    end else if (state_q == ST_IDLE && grant_val) begin
      l15_req_data_o <= (grant_src == SRC_DC) ? dc_req_data_i : ic_req_data_i;
      l15_req_src_o  <= grant_src;
      last_grant_q   <= grant_src;
    end
  end

  // Outstanding counters and sticky protocol-error flag.
  always_ff @(posedge clk_i or negedge reset_l) begin
    if (!reset_l) begin
      ic_cnt_q <= '0;
      dc_cnt_q <= '0;
      err_q    <= 1'b0;
    end else begin
      ic_cnt_q <= next_cnt(ic_cnt_q, ic_inc, ic_dec);
      dc_cnt_q <= next_cnt(dc_cnt_q, dc_inc, dc_dec);
      if ((state_q == ST_IDLE && l15_req_ack_i) ||
          (ic_dec && ic_cnt_q == '0) || (dc_dec && dc_cnt_q == '0))
        err_q <= 1'b1;
    end
  end

  assign ic_outst_o = ic_cnt_q;
  assign dc_outst_o = dc_cnt_q;
  assign err_o      = err_q;

endmodule

// File: tb/tb_lagarto_l15_req_arbiter.sv
// Bench for lagarto_l15_req_arbiter: directed scenarios plus a randomized run,
// all compared against a transaction-level model of grants, counts and errors.
module tb_lagarto_l15_req_arbiter;

  localparam int REQ_W     = 128;
  localparam int MAX_OUTST = 4;
  localparam int CNT_W     = 3;

  logic             clk_i = 1'b0;
  logic             reset_l = 1'b1;
  logic             ic_req_val_i = 1'b0;
  logic [REQ_W-1:0] ic_req_data_i = '0;
  logic             ic_req_ack_o;
  logic             dc_req_val_i = 1'b0;
  logic [REQ_W-1:0] dc_req_data_i = '0;
  logic             dc_req_ack_o;
  logic             l15_req_val_o;
  logic [REQ_W-1:0] l15_req_data_o;
  logic             l15_req_src_o;
  logic             l15_req_ack_i = 1'b0;
  logic             l15_rtrn_val_i = 1'b0;
  logic             l15_rtrn_src_i = 1'b0;
  logic             ic_rtrn_val_o;
  logic             dc_rtrn_val_o;
  logic [CNT_W-1:0] ic_outst_o;
  logic [CNT_W-1:0] dc_outst_o;
  logic             idle_o;
  logic             err_o;

  lagarto_l15_req_arbiter #(.REQ_W(REQ_W), .MAX_OUTST(MAX_OUTST), .CNT_W(CNT_W)) dut (
    .clk_i(clk_i), .reset_l(reset_l),
    .ic_req_val_i(ic_req_val_i), .ic_req_data_i(ic_req_data_i), .ic_req_ack_o(ic_req_ack_o),
    .dc_req_val_i(dc_req_val_i), .dc_req_data_i(dc_req_data_i), .dc_req_ack_o(dc_req_ack_o),
    .l15_req_val_o(l15_req_val_o), .l15_req_data_o(l15_req_data_o),
    .l15_req_src_o(l15_req_src_o), .l15_req_ack_i(l15_req_ack_i),
    .l15_rtrn_val_i(l15_rtrn_val_i), .l15_rtrn_src_i(l15_rtrn_src_i),
    .ic_rtrn_val_o(ic_rtrn_val_o), .dc_rtrn_val_o(dc_rtrn_val_o),
    .ic_outst_o(ic_outst_o), .dc_outst_o(dc_outst_o),
    .idle_o(idle_o), .err_o(err_o)
  );

  always #5 clk_i = ~clk_i;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: one pending slot, per-requester counts, sticky error.
  bit               m_busy;
  bit               m_src;
  bit               m_last;
  logic [REQ_W-1:0] m_data;
  int               m_cnt[2];
  bit               m_err;

  task automatic chk(input string tag, input logic [REQ_W-1:0] obs, input logic [REQ_W-1:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_busy = 0; m_src = 0; m_last = 1; m_data = '0;
    m_cnt[0] = 0; m_cnt[1] = 0; m_err = 0;
  endtask

  task automatic drive(input bit icv, input logic [REQ_W-1:0] icd, input bit dcv,
                       input logic [REQ_W-1:0] dcd, input bit ack, input bit rv, input bit rs);
    ic_req_val_i = icv; ic_req_data_i = icd;
    dc_req_val_i = dcv; dc_req_data_i = dcd;
    l15_req_ack_i = ack; l15_rtrn_val_i = rv; l15_rtrn_src_i = rs;
    #1;
  endtask

  task automatic check_model();
    bit ack_now;
    ack_now = m_busy && l15_req_ack_i;
    chk("l15_val",  REQ_W'(l15_req_val_o), REQ_W'(m_busy));
    chk("l15_src",  REQ_W'(l15_req_src_o), REQ_W'(m_src));
    chk("l15_data", l15_req_data_o, m_data);
    chk("ic_ack",   REQ_W'(ic_req_ack_o), REQ_W'(ack_now && !m_src));
    chk("dc_ack",   REQ_W'(dc_req_ack_o), REQ_W'(ack_now && m_src));
    chk("ic_rtrn",  REQ_W'(ic_rtrn_val_o), REQ_W'(l15_rtrn_val_i && !l15_rtrn_src_i));
    chk("dc_rtrn",  REQ_W'(dc_rtrn_val_o), REQ_W'(l15_rtrn_val_i && l15_rtrn_src_i));
    chk("ic_outst", REQ_W'(ic_outst_o), REQ_W'(m_cnt[0]));
    chk("dc_outst", REQ_W'(dc_outst_o), REQ_W'(m_cnt[1]));
    chk("idle",     REQ_W'(idle_o), REQ_W'(!m_busy && m_cnt[0] == 0 && m_cnt[1] == 0));
    chk("err",      REQ_W'(err_o), REQ_W'(m_err));
  endtask

  task automatic model_update();
    int  inc[2];
    int  dec[2];
    bit  e_ic, e_dc, pick;
    inc[0] = 0; inc[1] = 0; dec[0] = 0; dec[1] = 0;
    if (m_busy) begin
      if (l15_req_ack_i) begin
        inc[m_src] = 1;
        m_busy = 0;
      end
    end else begin
      if (l15_req_ack_i) m_err = 1;
      e_ic = ic_req_val_i && (m_cnt[0] < MAX_OUTST);
      e_dc = dc_req_val_i && (m_cnt[1] < MAX_OUTST);
      if (e_ic || e_dc) begin
        pick   = (e_ic && e_dc) ? !m_last : e_dc;
        m_busy = 1;
        m_src  = pick;
        m_data = pick ? dc_req_data_i : ic_req_data_i;
        m_last = pick;
      end
    end
    if (l15_rtrn_val_i) dec[l15_rtrn_src_i] = 1;
    for (int k = 0; k < 2; k++) begin
      if (dec[k] == 1 && m_cnt[k] == 0) m_err = 1;
      m_cnt[k] = m_cnt[k] + inc[k] - dec[k];
      if (m_cnt[k] < 0) m_cnt[k] = 0;
    end
  endtask

  task automatic tick();
    check_model();
    model_update();
    @(posedge clk_i);
    @(negedge clk_i);
  endtask

  task automatic step(input bit icv, input logic [REQ_W-1:0] icd, input bit dcv,
                      input logic [REQ_W-1:0] dcd, input bit ack, input bit rv, input bit rs);
    drive(icv, icd, dcv, dcd, ack, rv, rs);
    tick();
  endtask

  // Asserts reset at a non-edge instant and checks the asynchronous clear.
  task automatic apply_reset();
    reset_l = 1'b0;
    #1;
    chk("rst_val",   REQ_W'(l15_req_val_o), '0);
    chk("rst_src",   REQ_W'(l15_req_src_o), '0);
    chk("rst_data",  l15_req_data_o, '0);
    chk("rst_ic_cnt", REQ_W'(ic_outst_o), '0);
    chk("rst_dc_cnt", REQ_W'(dc_outst_o), '0);
    chk("rst_idle",  REQ_W'(idle_o), REQ_W'(1));
    chk("rst_err",   REQ_W'(err_o), '0);
    chk("rst_ic_ack", REQ_W'(ic_req_ack_o), '0);
    chk("rst_dc_ack", REQ_W'(dc_req_ack_o), '0);
    drive(0, '0, 0, '0, 0, 0, 0);
    model_reset();
    @(negedge clk_i);
    reset_l = 1'b1;
  endtask

  initial begin
    logic [REQ_W-1:0] icd, dcd;
    bit rv, rs, ack;

    @(negedge clk_i);
    apply_reset();

    // Single IC request: grant next cycle, ack at cycle 3.
    drive(1, REQ_W'(8'hA5), 0, '0, 0, 0, 0); tick();
    chk("s1_val_c1",  REQ_W'(l15_req_val_o), REQ_W'(1));
    chk("s1_src_c1",  REQ_W'(l15_req_src_o), '0);
    chk("s1_data_c1", l15_req_data_o, REQ_W'(8'hA5));
    step(1, REQ_W'(8'hA5), 0, '0, 0, 0, 0);
    step(1, REQ_W'(8'hA5), 0, '0, 0, 0, 0);
    drive(1, REQ_W'(8'hA5), 0, '0, 1, 0, 0);
    chk("s1_ic_ack_c3", REQ_W'(ic_req_ack_o), REQ_W'(1));
    chk("s1_dc_ack_c3", REQ_W'(dc_req_ack_o), '0);
    tick();
    chk("s1_ic_cnt_c4", REQ_W'(ic_outst_o), REQ_W'(1));
    chk("s1_val_c4",    REQ_W'(l15_req_val_o), '0);
    step(0, '0, 0, '0, 0, 0, 0);

    // Both requesters held valid, ack in first REQ cycle: IC, DC, IC, DC.
    apply_reset();
    for (int i = 0; i < 8; i++) begin
      drive(1, REQ_W'(32'h1C00 + i), 1, REQ_W'(32'hDC00 + i), (i % 2) == 1, 0, 0);
      chk("s2_val", REQ_W'(l15_req_val_o), REQ_W'((i % 2) == 1));
      if ((i % 2) == 1) chk("s2_order", REQ_W'(l15_req_src_o), REQ_W'((i / 2) % 2));
      tick();
    end

    // DC fills to MAX_OUTST; IC still granted; a DC return re-enables DC.
    apply_reset();
    for (int i = 0; i < 8; i++) step(0, '0, 1, REQ_W'(i), (i % 2) == 1, 0, 0);
    chk("s3_dc_full", REQ_W'(dc_outst_o), REQ_W'(4));
    step(1, REQ_W'(32'h1111), 1, REQ_W'(32'h5555), 0, 0, 0);
    chk("s3_ic_val", REQ_W'(l15_req_val_o), REQ_W'(1));
    chk("s3_ic_src", REQ_W'(l15_req_src_o), '0);
    drive(1, REQ_W'(32'h1111), 1, REQ_W'(32'h5555), 1, 0, 0);
    chk("s3_ic_ack", REQ_W'(ic_req_ack_o), REQ_W'(1));
    tick();
    chk("s3_no_dc_grant", REQ_W'(l15_req_val_o), '0);
    drive(0, '0, 1, REQ_W'(32'h5555), 0, 1, 1);
    chk("s3_dc_rtrn", REQ_W'(dc_rtrn_val_o), REQ_W'(1));
    tick();
    chk("s3_dc_cnt3", REQ_W'(dc_outst_o), REQ_W'(3));
    chk("s3_val_wait", REQ_W'(l15_req_val_o), '0);
    step(0, '0, 1, REQ_W'(32'h5555), 0, 0, 0);
    chk("s3_dc_val", REQ_W'(l15_req_val_o), REQ_W'(1));
    chk("s3_dc_src", REQ_W'(l15_req_src_o), REQ_W'(1));
    chk("s3_dc_data", l15_req_data_o, REQ_W'(32'h5555));
    step(0, '0, 1, REQ_W'(32'h5555), 1, 0, 0);

    // DC return coincides with DC ack at count 2.
    apply_reset();
    for (int i = 0; i < 5; i++) step(0, '0, 1, REQ_W'(i), (i % 2) == 1, 0, 0);
    chk("s4_dc_cnt2", REQ_W'(dc_outst_o), REQ_W'(2));
    drive(0, '0, 1, REQ_W'(9), 1, 1, 1);
    chk("s4_dc_ack",  REQ_W'(dc_req_ack_o), REQ_W'(1));
    chk("s4_dc_rtrn", REQ_W'(dc_rtrn_val_o), REQ_W'(1));
    tick();
    chk("s4_dc_cnt_same", REQ_W'(dc_outst_o), REQ_W'(2));

    // IC return underflow sets a sticky error.
    apply_reset();
    drive(0, '0, 0, '0, 0, 1, 0);
    chk("s5_ic_rtrn", REQ_W'(ic_rtrn_val_o), REQ_W'(1));
    tick();
    chk("s5_err", REQ_W'(err_o), REQ_W'(1));
    chk("s5_ic_cnt0", REQ_W'(ic_outst_o), '0);
    for (int i = 0; i < 3; i++) step(0, '0, 0, '0, 0, 0, 0);
    chk("s5_err_sticky", REQ_W'(err_o), REQ_W'(1));

    // Header ack while idle is a protocol error.
    apply_reset();
    step(0, '0, 0, '0, 1, 0, 0);
    chk("s5_ack_idle_err", REQ_W'(err_o), REQ_W'(1));

    // Randomized traffic against the model.
    apply_reset();
    for (int i = 0; i < 600; i++) begin
      icd = {$urandom, $urandom, $urandom, $urandom};
      dcd = {$urandom, $urandom, $urandom, $urandom};
      ack = m_busy && ($urandom_range(0, 2) != 0);
      rs  = $urandom_range(0, 1);
      rv  = ($urandom_range(0, 2) == 0);
      if (m_cnt[rs] == 0) begin
        rs = !rs;
        if (m_cnt[rs] == 0) rv = 0;
      end
      step($urandom_range(0, 1), icd, $urandom_range(0, 1), dcd, ack, rv, rs);
    end

    // Reset mid-transaction with three DC transactions outstanding.
    apply_reset();
    for (int i = 0; i < 7; i++) step(0, '0, 1, REQ_W'(i), (i % 2) == 1, 0, 0);
    chk("s6_in_req", REQ_W'(l15_req_val_o), REQ_W'(1));
    chk("s6_dc_cnt3", REQ_W'(dc_outst_o), REQ_W'(3));
    #2;
    apply_reset();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
